// File: rtl/branch_predictor_gshare_if.sv
// Fetch/resolve-side bundle for the gshare predictor: lookup request/response plus the update channel.
interface branch_predictor_gshare_if #(
  parameter int PC_W   = 14,
  parameter int IDX_W  = 10,
  parameter int HIST_W = 8
);
  logic              mode;
  logic              ready;
  logic              pred_en;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic [HIST_W-1:0] pred_ghr;
  logic              upd_en;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [HIST_W-1:0] upd_ghr;

  modport master (
    output mode, pred_en, pred_pc, upd_en, upd_idx, upd_taken, upd_mispredict, upd_ghr,
    input  ready, pred_valid, pred_taken, pred_idx, pred_ghr
  );

  modport slave (
    input  mode, pred_en, pred_pc, upd_en, upd_idx, upd_taken, upd_mispredict, upd_ghr,
    output ready, pred_valid, pred_taken, pred_idx, pred_ghr
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Bimodal/gshare direction predictor: saturating-counter table, speculative global history
// with mispredict recovery, and a one-entry-per-cycle init sweep after reset.
//   state   | meaning
//   ST_INIT | sweeping INIT_CTR into every entry; requests ignored
//   ST_RUN  | ready; serving lookups and updates
module branch_predictor_gshare #(
  parameter int PC_W     = 14,
  parameter int IDX_W    = 10,
  parameter int CTR_W    = 2,
  parameter int HIST_W   = 8,
  parameter int INIT_CTR = 0
) (
  input logic clk,
  input logic rst,
  branch_predictor_gshare_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  sweep_idx;
  logic [HIST_W-1:0] ghr;
  logic [CTR_W-1:0]  ctr_tbl [DEPTH];

  logic [IDX_W-1:0]  lookup_idx;
  logic [CTR_W-1:0]  lookup_ctr;
  logic              lookup_taken;
  logic [CTR_W-1:0]  upd_ctr;
  logic [CTR_W-1:0]  upd_next;
  logic [HIST_W-1:0] ghr_spec;
  logic [HIST_W-1:0] ghr_recover;

  always_comb begin
    lookup_idx = IDX_W'(bus.pred_pc);
    if (bus.mode) lookup_idx = IDX_W'(bus.pred_pc) ^ IDX_W'(ghr);
    lookup_ctr   = ctr_tbl[lookup_idx];
    lookup_taken = lookup_ctr[CTR_W-1];

    upd_ctr  = ctr_tbl[bus.upd_idx];
    upd_next = upd_ctr;
    if (bus.upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_next = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) upd_next = upd_ctr - CTR_W'(1);
    end

    // Truncating the concatenation drops the oldest history bit.
    ghr_spec    = HIST_W'({ghr, lookup_taken});
    ghr_recover = HIST_W'({bus.upd_ghr, bus.upd_taken});
  end

  // Table has no reset of its own; the sweep initialises it. Lookups read the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == ST_INIT) ctr_tbl[sweep_idx] <= CTR_W'(INIT_CTR);
      else if (bus.upd_en) ctr_tbl[bus.upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_INIT;
      sweep_idx      <= '0;
      ghr            <= '0;
      bus.ready      <= 1'b0;
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_idx   <= '0;
      bus.pred_ghr   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          bus.pred_valid <= 1'b0;
          sweep_idx      <= sweep_idx + IDX_W'(1);
          if (sweep_idx == '1) begin
            state     <= ST_RUN;
            bus.ready <= 1'b1;
          end
        end
        ST_RUN: begin
          bus.pred_valid <= bus.pred_en;
          if (bus.pred_en) begin
            bus.pred_taken <= lookup_taken;
            bus.pred_idx   <= lookup_idx;
            bus.pred_ghr   <= ghr;
          end
          if (bus.upd_en && bus.upd_mispredict) ghr <= ghr_recover;
          else if (bus.pred_en) ghr <= ghr_spec;
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule
